// File: rtl/tlp_rxcpl_buffer_if.sv
// rtl/tlp_rxcpl_buffer_if.sv - reservation, completion-write and read-data signals of the RX completion buffer
interface tlp_rxcpl_buffer_if #(
    parameter int W = 8
);
    logic           RdReqValid_i;
    logic [W:0]     RdReqDwLen_i;
    logic           RdReqGrant_o;
    logic           CplWrValid_i;
    logic [127:0]   CplWrData_i;
    logic [2:0]     CplWrDwCnt_i;
    logic           CplWrReady_o;
    logic [31:0]    RxReadData_o;
    logic           RxReadDataValid_o;
    logic           RxReadDataReady_i;
    logic [W:0]     CplBuffFreeDw_o;
    logic           CplBuffErr_o;

    modport slave (
        input  RdReqValid_i, RdReqDwLen_i, CplWrValid_i, CplWrData_i, CplWrDwCnt_i, RxReadDataReady_i,
        output RdReqGrant_o, CplWrReady_o, RxReadData_o, RxReadDataValid_o, CplBuffFreeDw_o, CplBuffErr_o
    );

    modport master (
        output RdReqValid_i, RdReqDwLen_i, CplWrValid_i, CplWrData_i, CplWrDwCnt_i, RxReadDataReady_i,
        input  RdReqGrant_o, CplWrReady_o, RxReadData_o, RxReadDataValid_o, CplBuffFreeDw_o, CplBuffErr_o
    );
endinterface

// File: rtl/tlp_rxcpl_buffer.sv
// rtl/tlp_rxcpl_buffer.sv - RX completion buffer: 4-bank dword ring with space reservation; optional RXCPL_BUFF_ERR_CHK_EN
module tlp_rxcpl_buffer #(
    parameter int RXCPL_BUFF_ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    tlp_rxcpl_buffer_if.slave   bus
);
    localparam int W    = RXCPL_BUFF_ADDR_WIDTH;
    localparam int ROWS = 2 ** (W - 2);
    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    logic [31:0]    mem [4][ROWS];

    logic [W-1:0]   wrPtr, rdPtr;
    logic [W:0]     occ, rsv, freeDw;
    logic           outValid;
    logic [31:0]    outData;

    logic           grant, wrAccept, wrOk, pop, load;
    logic [W:0]     grantLen, wrCnt, pending;
    logic [31:0]    rdData;

    logic [1:0]     laneIdx [4];
    logic           wrEn    [4];
    logic [W-3:0]   wrRow   [4];
    logic [31:0]    wrData  [4];

    // Free space uses registered counters only, so a pop frees space a cycle later.
    assign freeDw   = DEPTH - occ - rsv;
    assign grant    = ~rst & bus.RdReqValid_i & (bus.RdReqDwLen_i <= freeDw);
    assign grantLen = grant ? bus.RdReqDwLen_i : '0;

    assign bus.RdReqGrant_o      = grant;
    assign bus.CplWrReady_o      = ~rst;
    assign bus.CplBuffFreeDw_o   = freeDw;
    assign bus.RxReadData_o      = outData;
    assign bus.RxReadDataValid_o = outValid;

    assign wrAccept = bus.CplWrValid_i & bus.CplWrReady_o;

`ifdef RXCPL_BUFF_ERR_CHK_EN
    logic badBeat, errQ;

    assign badBeat = (bus.CplWrDwCnt_i == 3'd0) | (bus.CplWrDwCnt_i > 3'd4)
                   | ((W+1)'(bus.CplWrDwCnt_i) > rsv);
    assign wrOk    = wrAccept & ~badBeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            errQ <= 1'b0;
        end else if (wrAccept & badBeat) begin
            errQ <= 1'b1;
        end
    end

    assign bus.CplBuffErr_o = errQ;
`else
    assign wrOk             = wrAccept;
    assign bus.CplBuffErr_o = 1'b0;
`endif

    assign wrCnt = wrOk ? (W+1)'(bus.CplWrDwCnt_i) : '0;

    // Bank b receives input lane (b - wrPtr[1:0]); its row advances when the lane index carries past bank 3.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            laneIdx[b] = 2'(b) - wrPtr[1:0];
            wrEn[b]    = wrOk & ({1'b0, laneIdx[b]} < bus.CplWrDwCnt_i);
            wrRow[b]   = wrPtr[W-1:2]
                       + (W-2)'((3'(wrPtr[1:0]) + 3'(laneIdx[b])) > 3'd3);
            wrData[b]  = bus.CplWrData_i[32*laneIdx[b] +: 32];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wrEn[b]) begin
                mem[b][wrRow[b]] <= wrData[b];
            end
        end
    end

    assign rdData  = mem[rdPtr[1:0]][rdPtr[W-1:2]];
    assign pop     = outValid & bus.RxReadDataReady_i;
    assign pending = occ - (W+1)'(outValid);
    assign load    = (~outValid | pop) & (pending != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            occ      <= '0;
            rsv      <= '0;
            outValid <= 1'b0;
            outData  <= '0;
        end else begin
            wrPtr <= wrPtr + W'(wrCnt);
            occ   <= occ + wrCnt - (W+1)'(pop);
            rsv   <= rsv + grantLen - wrCnt;
            if (load) begin
                outData  <= rdData;
                outValid <= 1'b1;
                rdPtr    <= rdPtr + 1'b1;
            end else if (pop) begin
                outValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tlp_rxcpl_buffer.sv
// tb/tb_tlp_rxcpl_buffer.sv - scoreboard bench for tlp_rxcpl_buffer
module tb_tlp_rxcpl_buffer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] sb [$];
    logic        holdPrev = 1'b0;
    logic [31:0] holdData = '0;

    tlp_rxcpl_buffer_if #(.W(W)) bus ();

    tlp_rxcpl_buffer #(.RXCPL_BUFF_ADDR_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drvBeat(input logic [127:0] d, input int cnt, input bit push);
        bus.CplWrValid_i = 1'b1;
        bus.CplWrData_i  = d;
        bus.CplWrDwCnt_i = 3'(cnt);
        if (push) begin
            for (int k = 0; k < cnt; k++) sb.push_back(d[32*k +: 32]);
        end
    endtask

    task automatic reserve(input int len, input logic expGrant);
        bus.RdReqValid_i = 1'b1;
        bus.RdReqDwLen_i = (W+1)'(len);
        @(negedge clk);
        check("grant", 32'(bus.RdReqGrant_o), 32'(expGrant));
        tick();
        bus.RdReqValid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.RxReadDataValid_o) done = 1;
        end
        if (!done) check(tag, 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard pop on every handshake; a stalled output must keep its data.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (rst) begin
            holdPrev = 1'b0;
        end else begin
            if (holdPrev) begin
                check("hold_valid", 32'(bus.RxReadDataValid_o), 32'd1);
                check("hold_data", bus.RxReadData_o, holdData);
            end
            if (bus.RxReadDataValid_o && bus.RxReadDataReady_i) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEADBEEF;
                check("rd_data", bus.RxReadData_o, exp);
            end
            holdPrev = bus.RxReadDataValid_o & ~bus.RxReadDataReady_i;
            holdData = bus.RxReadData_o;
        end
    end

    initial begin
        logic [127:0] d;

        bus.RdReqValid_i      = 1'b1;
        bus.RdReqDwLen_i      = (W+1)'(1);
        bus.CplWrValid_i      = 1'b0;
        bus.CplWrData_i       = '0;
        bus.CplWrDwCnt_i      = '0;
        bus.RxReadDataReady_i = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 32'(bus.RxReadDataValid_o), 32'd0);
        check("rst_data", bus.RxReadData_o, 32'd0);
        check("rst_free", 32'(bus.CplBuffFreeDw_o), 32'd256);
        check("rst_err", 32'(bus.CplBuffErr_o), 32'd0);
        check("rst_ready", 32'(bus.CplWrReady_o), 32'd0);
        check("rst_grant", 32'(bus.RdReqGrant_o), 32'd0);
        tick();
        rst = 1'b0;
        bus.RdReqValid_i = 1'b0;

        // Reserve 16, then stream 16 dwords through.
        reserve(16, 1'b1);
        @(negedge clk);
        check("free_240", 32'(bus.CplBuffFreeDw_o), 32'd240);
        check("wr_ready", 32'(bus.CplWrReady_o), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            d = {32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)};
            drvBeat(d, 4, 1'b1);
            @(negedge clk);
            check($sformatf("lat%0d", i), 32'(bus.RxReadDataValid_o), (i >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        bus.CplWrValid_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(bus.RxReadDataValid_o), 32'd1);
            tick();
        end
        @(negedge clk);
        check("stream_end", 32'(bus.RxReadDataValid_o), 32'd0);
        check("free_256", 32'(bus.CplBuffFreeDw_o), 32'd256);
        tick();

        // Move wr_ptr to 254, then write 4 dwords across the wrap point.
        doReset();
        reserve(254, 1'b1);
        for (int i = 0; i < 64; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            drvBeat(d, (i < 63) ? 4 : 2, 1'b1);
            tick();
        end
        bus.CplWrValid_i = 1'b0;
        drain("drain_prefill");
        reserve(4, 1'b1);
        drvBeat({32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A}, 4, 1'b1);
        tick();
        bus.CplWrValid_i = 1'b0;
        drain("drain_wrap");

        // Full buffer refuses grants; a pop frees one dword a cycle later.
        bus.RxReadDataReady_i = 1'b0;
        reserve(256, 1'b1);
        bus.RdReqValid_i = 1'b1;
        bus.RdReqDwLen_i = (W+1)'(1);
        drvBeat({32'h103, 32'h102, 32'h101, 32'h100}, 4, 1'b1);
        @(negedge clk);
        check("full_grant", 32'(bus.RdReqGrant_o), 32'd0);
        check("full_free", 32'(bus.CplBuffFreeDw_o), 32'd0);
        tick();
        bus.CplWrValid_i = 1'b0;
        @(negedge clk);
        check("full_grant2", 32'(bus.RdReqGrant_o), 32'd0);
        check("full_valid_n1", 32'(bus.RxReadDataValid_o), 32'd0);
        tick();
        @(negedge clk);
        check("full_valid_n2", 32'(bus.RxReadDataValid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("stall_grant", 32'(bus.RdReqGrant_o), 32'd0);
        end
        tick();
        bus.RxReadDataReady_i = 1'b1;
        @(negedge clk);
        check("pop_cycle_grant", 32'(bus.RdReqGrant_o), 32'd0);
        tick();
        bus.RxReadDataReady_i = 1'b0;
        @(negedge clk);
        check("after_pop_free", 32'(bus.CplBuffFreeDw_o), 32'd1);
        check("after_pop_grant", 32'(bus.RdReqGrant_o), 32'd1);
        tick();
        bus.RdReqValid_i = 1'b0;
        @(negedge clk);
        check("refull_free", 32'(bus.CplBuffFreeDw_o), 32'd0);
        tick();

        // Reset with data pending discards everything.
        doReset();
        @(negedge clk);
        check("midrst_valid", 32'(bus.RxReadDataValid_o), 32'd0);
        check("midrst_free", 32'(bus.CplBuffFreeDw_o), 32'd256);
        tick();
        bus.RxReadDataReady_i = 1'b1;

`ifdef RXCPL_BUFF_ERR_CHK_EN
        reserve(2, 1'b1);
        drvBeat({32'h0, 32'h3, 32'h2, 32'h1}, 3, 1'b0);
        @(negedge clk);
        check("err_pre", 32'(bus.CplBuffErr_o), 32'd0);
        tick();
        bus.CplWrValid_i = 1'b0;
        @(negedge clk);
        check("err_set", 32'(bus.CplBuffErr_o), 32'd1);
        check("err_free", 32'(bus.CplBuffFreeDw_o), 32'd254);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("err_sticky", 32'(bus.CplBuffErr_o), 32'd1);
            check("err_dropped", 32'(bus.RxReadDataValid_o), 32'd0);
        end
        tick();
        doReset();
        @(negedge clk);
        check("err_cleared", 32'(bus.CplBuffErr_o), 32'd0);
        tick();
`else
        @(negedge clk);
        check("err_idle", 32'(bus.CplBuffErr_o), 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
